// File: rtl/rx_unstuff_shift.sv
`default_nettype none
// ============================================================================
// Module      : rx_unstuff_shift
// Description : USB receive stage that hunts SYNC, removes stuffed bits and
//               assembles LSB-first bytes, flagging stuff/alignment errors.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_unstuff_shift #(
  parameter logic [7:0]  SYNC_PATTERN = 8'h80,
  parameter int unsigned MAX_ONES     = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_orig,
  input  logic       shift_enable,
  input  logic       eop,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       sync_found,
  output logic       stuff_err,
  output logic       align_err,
  output logic       packet_done
);

  localparam logic [2:0] c_max_ones = 3'(MAX_ONES);

  typedef enum logic [1:0] {
    ST_HUNT = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_window, w_window_nxt;
  logic [7:0] r_shreg, w_shreg_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [2:0] r_ones_cnt, w_ones_cnt_nxt;
  logic       r_byte_valid, w_byte_valid_nxt;
  logic       r_sync_found, w_sync_found_nxt;
  logic       r_stuff_err, w_stuff_err_nxt;
  logic       r_align_err, w_align_err_nxt;
  logic       r_packet_done, w_packet_done_nxt;
  logic       w_accept;
  logic       w_eop_seen;

  assign w_accept   = shift_enable & ~eop;
  assign w_eop_seen = shift_enable & eop;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_HUNT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_window_nxt      = r_window;
    w_shreg_nxt       = r_shreg;
    w_rx_data_nxt     = r_rx_data;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_ones_cnt_nxt    = r_ones_cnt;
    w_byte_valid_nxt  = 1'b0;
    w_sync_found_nxt  = 1'b0;
    w_stuff_err_nxt   = 1'b0;
    w_align_err_nxt   = 1'b0;
    w_packet_done_nxt = 1'b0;

    if (w_accept) begin
      if (d_orig) w_ones_cnt_nxt = (r_ones_cnt == c_max_ones) ? r_ones_cnt : r_ones_cnt + 3'd1;
      else        w_ones_cnt_nxt = 3'd0;

      case (r_state)
        ST_HUNT: begin
          w_window_nxt = {d_orig, r_window[7:1]};
          if (w_window_nxt == SYNC_PATTERN) begin
            w_sync_found_nxt = 1'b1;
            w_bit_cnt_nxt    = 3'd0;
            w_state_nxt      = ST_DATA;
          end
        end
        ST_DATA: begin
          // After a run of MAX_ONES the next bit must be a stuffed zero.
          if (r_ones_cnt == c_max_ones) begin
            if (d_orig) begin
              w_stuff_err_nxt = 1'b1;
              w_state_nxt     = ST_ERR;
            end
          end else begin
            w_shreg_nxt   = {d_orig, r_shreg[7:1]};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_rx_data_nxt    = w_shreg_nxt;
              w_byte_valid_nxt = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end else if (w_eop_seen) begin
      w_window_nxt   = 8'hFF;
      w_ones_cnt_nxt = 3'd0;
      w_bit_cnt_nxt  = 3'd0;
      w_state_nxt    = ST_HUNT;
      if (r_state == ST_DATA) begin
        w_packet_done_nxt = 1'b1;
        w_align_err_nxt   = (r_bit_cnt != 3'd0);
      end else if (r_state == ST_ERR) begin
        w_packet_done_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_window      <= 8'hFF;
      r_shreg       <= 8'h00;
      r_rx_data     <= 8'h00;
      r_bit_cnt     <= 3'd0;
      r_ones_cnt    <= 3'd0;
      r_byte_valid  <= 1'b0;
      r_sync_found  <= 1'b0;
      r_stuff_err   <= 1'b0;
      r_align_err   <= 1'b0;
      r_packet_done <= 1'b0;
    end else begin
      r_window      <= w_window_nxt;
      r_shreg       <= w_shreg_nxt;
      r_rx_data     <= w_rx_data_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_ones_cnt    <= w_ones_cnt_nxt;
      r_byte_valid  <= w_byte_valid_nxt;
      r_sync_found  <= w_sync_found_nxt;
      r_stuff_err   <= w_stuff_err_nxt;
      r_align_err   <= w_align_err_nxt;
      r_packet_done <= w_packet_done_nxt;
    end
  end

  assign rx_data     = r_rx_data;
  assign byte_valid  = r_byte_valid;
  assign sync_found  = r_sync_found;
  assign stuff_err   = r_stuff_err;
  assign align_err   = r_align_err;
  assign packet_done = r_packet_done;

endmodule
`default_nettype wire

// File: tb/tb_rx_unstuff_shift.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_unstuff_shift
// Description : Self-checking bench for rx_unstuff_shift against a bit-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_unstuff_shift;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_orig;
  logic       shift_enable;
  logic       eop;
  logic [7:0] rx_data;
  logic       byte_valid, sync_found, stuff_err, align_err, packet_done;

  rx_unstuff_shift dut (
    .clk(clk), .n_rst(n_rst), .d_orig(d_orig), .shift_enable(shift_enable), .eop(eop),
    .rx_data(rx_data), .byte_valid(byte_valid), .sync_found(sync_found),
    .stuff_err(stuff_err), .align_err(align_err), .packet_done(packet_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: mode 0 hunting, 1 receiving, 2 errored; run = consecutive ones,
  // zrun = consecutive zeros seen while hunting.
  int         m_mode, m_run, m_zrun, m_nbits;
  logic [7:0] m_acc;
  logic [7:0] exp_rx = 8'h00;
  logic       exp_bv = 1'b0, exp_sf = 1'b0, exp_se = 1'b0, exp_al = 1'b0, exp_pd = 1'b0;

  initial begin
    m_mode = 0; m_run = 0; m_zrun = 0; m_nbits = 0; m_acc = 8'h00;
    forever begin
      @(posedge clk or negedge n_rst);
      exp_bv = 1'b0; exp_sf = 1'b0; exp_se = 1'b0; exp_al = 1'b0; exp_pd = 1'b0;
      if (!n_rst) begin
        m_mode = 0; m_run = 0; m_zrun = 0; m_nbits = 0; m_acc = 8'h00;
        exp_rx = 8'h00;
      end else if (shift_enable && !eop) begin
        if (m_mode == 0) begin
          if (d_orig && m_zrun >= 7) begin
            exp_sf = 1'b1; m_mode = 1; m_nbits = 0; m_acc = 8'h00;
          end
          m_zrun = d_orig ? 0 : m_zrun + 1;
        end else if (m_mode == 1) begin
          if (m_run == 6) begin
            if (d_orig) begin exp_se = 1'b1; m_mode = 2; end
          end else begin
            m_acc[m_nbits] = d_orig;
            m_nbits++;
            if (m_nbits == 8) begin exp_rx = m_acc; exp_bv = 1'b1; m_nbits = 0; end
          end
        end
        m_run = d_orig ? m_run + 1 : 0;
      end else if (shift_enable && eop) begin
        if (m_mode == 1) begin exp_pd = 1'b1; exp_al = (m_nbits != 0); end
        if (m_mode == 2) exp_pd = 1'b1;
        m_mode = 0; m_run = 0; m_zrun = 0; m_nbits = 0;
      end
    end
  end

  int         cnt_bv = 0, cnt_sf = 0, cnt_se = 0, cnt_al = 0, cnt_pd = 0;
  logic [7:0] last_rx = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      check("rx_data",     rx_data,     exp_rx);
      check("byte_valid",  byte_valid,  exp_bv);
      check("sync_found",  sync_found,  exp_sf);
      check("stuff_err",   stuff_err,   exp_se);
      check("align_err",   align_err,   exp_al);
      check("packet_done", packet_done, exp_pd);
      if (byte_valid) begin cnt_bv++; last_rx = rx_data; end
      if (sync_found)  cnt_sf++;
      if (stuff_err)   cnt_se++;
      if (align_err)   cnt_al++;
      if (packet_done) cnt_pd++;
    end
  end

  int gap   = 0;
  int g_run = 0;

  task automatic cycle(input logic se, input logic e, input logic d);
    shift_enable = se; eop = e; d_orig = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send(input logic d);
    idle(gap);
    cycle(1'b1, 1'b0, d);
  endtask

  task automatic send_eop();
    idle(gap);
    cycle(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_sync();
    repeat (7) send(1'b0);
    send(1'b1);
    check("sync_pulse", sync_found, 1'b1);
    g_run = 1;
  endtask

  // Sends a byte LSB-first, inserting stuffed zeros; err_pct chance of a bad stuff bit.
  task automatic send_byte(input logic [7:0] b, input int err_pct);
    for (int i = 0; i < 8; i++) begin
      if (g_run == 6) begin
        send(($urandom_range(0, 99) < err_pct) ? 1'b1 : 1'b0);
        g_run = 0;
      end
      send(b[i]);
      g_run = b[i] ? g_run + 1 : 0;
    end
  endtask

  int b_bv, b_pd, b_al;

  initial begin
    shift_enable = 1'b0; eop = 1'b0; d_orig = 1'b0; n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {byte_valid, sync_found, stuff_err, align_err, packet_done}, 5'b0);

    // Idle ones never look like SYNC
    repeat (20) send(1'b1);
    idle(1);
    check("idle_pulses", cnt_bv + cnt_sf + cnt_se + cnt_al + cnt_pd, 0);
    check("idle_rx_data", rx_data, 8'h00);

    // SYNC + 0xA5 + eop
    send_sync();
    send_byte(8'hA5, 0);
    check("a5_valid", byte_valid, 1'b1);
    check("a5_data", rx_data, 8'hA5);
    send_eop();
    check("a5_done", packet_done, 1'b1);
    check("a5_align", align_err, 1'b0);

    // 0xFF with a stuffed zero after the sixth one, without and with gaps
    for (int g = 0; g <= 3; g += 3) begin
      gap = g;
      idle(1);
      b_bv = cnt_bv;
      send_sync();
      repeat (5) send(1'b1);
      send(1'b0);
      repeat (3) send(1'b1);
      check("ff_data", rx_data, 8'hFF);
      send_eop();
      check("ff_no_align", align_err, 1'b0);
      idle(1);
      check("ff_byte_count", cnt_bv - b_bv, 1);
    end
    gap = 0;

    // Stuff violation then ignored bits
    send_sync();
    repeat (5) send(1'b1);
    send(1'b1);
    check("stuff_err_pulse", stuff_err, 1'b1);
    b_bv = cnt_bv;
    repeat (6) begin send(1'b1); send(1'b0); end
    idle(1);
    check("err_no_bytes", cnt_bv - b_bv, 0);
    send_eop();
    check("err_done", packet_done, 1'b1);
    check("err_no_align", align_err, 1'b0);
    send_sync();
    send_eop();

    // Misaligned packet, then a clean one
    send_sync();
    send_byte(8'h3C, 0);
    check("3c_data", rx_data, 8'h3C);
    send(1'b1); send(1'b0); send(1'b1);
    send_eop();
    check("mis_align", align_err, 1'b1);
    check("mis_done", packet_done, 1'b1);
    send_sync();
    send_byte(8'h01, 0);
    send_eop();
    idle(1);
    check("01_data", last_rx, 8'h01);

    // Asynchronous reset mid-packet
    b_pd = cnt_pd;
    send_sync();
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    #2 n_rst = 1'b0;
    #1;
    check("arst_rx_data", rx_data, 8'h00);
    check("arst_pulses", {byte_valid, sync_found, stuff_err, align_err, packet_done}, 5'b0);
    @(posedge clk);
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
    send_sync();
    send_byte(8'h5A, 0);
    check("5a_data", rx_data, 8'h5A);
    send_eop();
    idle(1);
    check("arst_no_done", cnt_pd - b_pd, 1);

    // Randomized packets with occasional stuff violations and misalignment
    b_al = cnt_al;
    for (int p = 0; p < 40; p++) begin
      gap = $urandom_range(0, 2);
      repeat ($urandom_range(0, 6)) send(1'b1);
      send_sync();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) send_byte(8'($urandom), 8);
      repeat ($urandom_range(0, 3)) send(1'($urandom));
      send_eop();
    end
    gap = 0;

    // Unstructured traffic biased toward zeros so SYNC appears by chance
    repeat (600) cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), ($urandom_range(0, 2) == 0));
    cycle(1'b1, 1'b1, 1'b0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
